pipe_mul_param: RTL
===================

Name: pipe_mul_param

Overview:
- Parametrised pipelined integer multiplier; next generation of the team's fixed 4x4 pipelined multiplier.
- Adds generic operand width and configurable stage depth.
- Adds per-transaction signed/unsigned mode, a valid/ready handshake on both sides with backpressure, a transaction tag and a synchronous flush.
- Sits in datapath blocks that need a throughput-1 multiplier behind a stallable stream.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- PP_PER_STAGE, 2, partial products accumulated per stage; must divide WIDTH exactly.
- TAG_W, 4, width of the sideband tag carried with each operation.
- Derived, not overridable: NSTAGE = WIDTH/PP_PER_STAGE.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of all in-flight operations.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- mul_a  in  WIDTH  multiplicand.
- mul_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- mul_out  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the result.
- in_flight  out  $clog2(NSTAGE+1)  number of occupied stages.

Behaviour:
- Reset (async, active-high): all stage valid bits 0; out_valid=0; mul_out=0; out_tag=0; in_flight=0. in_ready follows from the empty pipeline.
- Stages S1..SNSTAGE. Each stage register holds {valid, signed, a_ext, b, partial_acc, tag}.
  - a_ext is mul_a extended to 2*WIDTH: sign-extended if signed, zero-extended otherwise.
- Stage k (input side feeding S1 is k=1) adds partial products for b bits i = (k-1)*PP_PER_STAGE .. k*PP_PER_STAGE-1.
  - Each term is b[i] ? (a_ext<<i) : 0.
  - For i = WIDTH-1 in signed mode the term is subtracted, not added.
- All arithmetic is modulo 2^(2*WIDTH).
- The result is exact for all operand values in both modes: unsigned 0..(2^WIDTH-1)^2; signed includes -2^(WIDTH-1) * -2^(WIDTH-1).
- Stage advance rules:
  - SNSTAGE advances when out_ready=1.
  - Sk (k<NSTAGE) loads from the previous stage when Sk is empty or Sk+1 loads this cycle (bubble-collapsing).
- in_ready = S1 empty OR S1 loads this cycle. Combinational from out_ready through the valid chain; no registered skid.
- A beat is accepted on a rising edge with in_valid & in_ready.
- Latency:
  - Result appears on mul_out/out_valid NSTAGE edges after acceptance when unstalled.
  - Throughput is 1 beat/cycle.
- Outputs: out_valid = SNSTAGE.valid; mul_out and out_tag are driven from SNSTAGE registers.
  - While out_valid & !out_ready, outputs are held stable.
- Ordering: results leave in acceptance order; no reordering, no drop, no duplication.
- Flush (sync, sampled on clk):
  - Next edge clears all valid bits.
  - A beat presented in the same cycle is NOT accepted (in_ready forced 0 while flush=1).
  - Data registers need not clear.
- Pipeline full with out_ready=0: in_ready=0 and all stages hold.
- Simultaneous out_ready and in_valid on a full pipeline: the whole pipe shifts and the beat is accepted.
- in_flight = population count of stage valid bits.
- Reset mid-operation: in-flight operations are discarded and reset values return immediately (async).

Decomposition:
- Package pipe_mul_pkg holds:
  - the stage record typedef (valid, signed, a_ext, b, acc, tag), parametrised via localparams;
  - the function pp_term(a_ext, b_bit, idx, is_signed, WIDTH) returning the signed/unsigned partial term.
- One natural sub-module: pipe_mul_stage.
  - Accumulates PP_PER_STAGE terms into its register.
  - Has load/hold control; generate-instantiated NSTAGE times.

Test Plan:
- WIDTH=8, PP_PER_STAGE=2 (NSTAGE=4) unless noted.
- Unsigned 0x0A*0x0A, then 0x0D*0x08, out_ready=1 -> mul_out 0x0064 then 0x0068, each exactly 4 edges after acceptance, tags echoed.
- Signed 0xFD*0x05 -> 0xFFF1; signed 0x80*0x80 -> 0x4000; unsigned 0xFF*0xFF -> 0xFE01; signed 0xFF*0xFF -> 0x0001.
- Back-to-back 8 beats with tags 0..7, out_ready low for cycles 3..8:
  - in_ready drops once in_flight=4;
  - outputs are held stable while stalled;
  - all 8 results arrive in tag order with correct values.
- Flush with 3 beats in flight and in_valid high in the same cycle -> next cycle in_flight=0 and out_valid=0; the concurrent beat never emerges.
- Assert rst mid-stream with 4 beats in flight -> out_valid=0, mul_out=0, in_flight=0 with no clock edge; after release, a new beat 0x03*0x07 -> 0x0015 with 4-cycle latency.
- Random regression, WIDTH=5, PP_PER_STAGE=1, random in_valid/out_ready/in_signed -> every result matches a reference model; order is preserved.

Source files
------------

// File: rtl/pipe_mul_pkg.sv
// Shared types and the partial-product helper for the pipelined multiplier.
// Operand width is limited to 32 bits so a product fits the 64-bit helper datapath.
package pipe_mul_pkg;

    localparam int MAX_PROD_W = 64;

    // Width-independent control part of every stage record.
    typedef struct packed {
        logic valid;
        logic is_signed;
    } stage_ctl_t;

    // One shift-and-add term; the top multiplier bit carries negative weight when signed.
    function automatic logic [MAX_PROD_W-1:0] pp_term(
        input logic [MAX_PROD_W-1:0] a_ext,
        input logic                  b_bit,
        input int unsigned           idx,
        input logic                  is_signed,
        input int unsigned           width
    );
        logic [MAX_PROD_W-1:0] t;
        t = b_bit ? (a_ext << idx) : '0;
        if (is_signed && (idx == width - 1)) begin
            t = -t;
        end
        return t;
    endfunction

endpackage

// File: rtl/pipe_mul_stage.sv
// One multiplier pipeline stage: folds PP_PER_STAGE partial products into the
// running accumulator and registers the whole operation record on load.
module pipe_mul_stage
    import pipe_mul_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PP_PER_STAGE = 2,
    parameter int TAG_W        = 4,
    parameter int STAGE_IDX    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               in_valid,
    input  logic               in_signed,
    input  logic [2*WIDTH-1:0] in_a_ext,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_acc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               valid,
    output logic               is_signed,
    output logic [2*WIDTH-1:0] a_ext,
    output logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic [TAG_W-1:0]   tag
);

    localparam int PW = 2 * WIDTH;

    typedef struct packed {
        stage_ctl_t        ctl;
        logic [PW-1:0]     a_ext;
        logic [WIDTH-1:0]  b;
        logic [PW-1:0]     acc;
        logic [TAG_W-1:0]  tag;
    } stage_rec_t;

    stage_rec_t    rec_d, rec_q;
    logic [PW-1:0] terms [PP_PER_STAGE];
    logic [PW-1:0] acc_sum;

    for (genvar j = 0; j < PP_PER_STAGE; j++) begin : g_term
        assign terms[j] = PW'(pp_term(MAX_PROD_W'(in_a_ext),
                                      in_b[STAGE_IDX*PP_PER_STAGE+j],
                                      STAGE_IDX * PP_PER_STAGE + j,
                                      in_signed,
                                      WIDTH));
    end

    // Sum wraps modulo 2^(2*WIDTH), which is exactly the product range.
    always_comb begin
        acc_sum = in_acc;
        for (int j = 0; j < PP_PER_STAGE; j++) begin
            acc_sum = acc_sum + terms[j];
        end
    end

    always_comb begin
        rec_d               = '0;
        rec_d.ctl.valid     = in_valid;
        rec_d.ctl.is_signed = in_signed;
        rec_d.a_ext         = in_a_ext;
        rec_d.b             = in_b;
        rec_d.acc           = acc_sum;
        rec_d.tag           = in_tag;
    end

    // Flush only drops the valid bit; data may still load and is simply ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_q <= '0;
        end else begin
            if (load) begin
                rec_q <= rec_d;
            end
            if (flush) begin
                rec_q.ctl.valid <= 1'b0;
            end
        end
    end

    assign valid     = rec_q.ctl.valid;
    assign is_signed = rec_q.ctl.is_signed;
    assign a_ext     = rec_q.a_ext;
    assign b         = rec_q.b;
    assign acc       = rec_q.acc;
    assign tag       = rec_q.tag;

endmodule

// File: rtl/pipe_mul_param.sv
// Parametrised pipelined multiplier with valid/ready on both sides, tag
// sideband, per-beat signed mode, synchronous flush and bubble collapsing.
module pipe_mul_param
    import pipe_mul_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PP_PER_STAGE = 2,
    parameter int TAG_W        = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic                                       in_signed,
    input  logic [WIDTH-1:0]                           mul_a,
    input  logic [WIDTH-1:0]                           mul_b,
    input  logic [TAG_W-1:0]                           in_tag,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [2*WIDTH-1:0]                         mul_out,
    output logic [TAG_W-1:0]                           out_tag,
    output logic [$clog2(WIDTH/PP_PER_STAGE+1)-1:0]    in_flight
);

    localparam int NSTAGE = WIDTH / PP_PER_STAGE;
    localparam int PW     = 2 * WIDTH;
    localparam int CNT_W  = $clog2(NSTAGE + 1);

    logic [NSTAGE-1:0] st_valid;
    logic [NSTAGE-1:0] st_signed;
    logic [NSTAGE-1:0] st_load;
    logic [PW-1:0]     st_a_ext [NSTAGE];
    logic [WIDTH-1:0]  st_b     [NSTAGE];
    logic [PW-1:0]     st_acc   [NSTAGE];
    logic [TAG_W-1:0]  st_tag   [NSTAGE];

    logic          in_fire;
    logic [PW-1:0] in_a_ext;
    logic          unused_tail;

    // A stage loads when empty or when its successor loads; the ripple runs from out_ready.
    always_comb begin
        logic carry;
        carry   = out_ready;
        st_load = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            st_load[k] = ~st_valid[k] | carry;
            carry      = st_load[k];
        end
    end

    assign in_ready = st_load[0] & ~flush;
    assign in_fire  = in_valid & in_ready;
    assign in_a_ext = in_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic              src_valid;
        logic              src_signed;
        logic [PW-1:0]     src_a_ext;
        logic [WIDTH-1:0]  src_b;
        logic [PW-1:0]     src_acc;
        logic [TAG_W-1:0]  src_tag;

        if (k == 0) begin : g_first
            assign src_valid  = in_fire;
            assign src_signed = in_signed;
            assign src_a_ext  = in_a_ext;
            assign src_b      = mul_b;
            assign src_acc    = '0;
            assign src_tag    = in_tag;
        end else begin : g_next
            assign src_valid  = st_valid[k-1];
            assign src_signed = st_signed[k-1];
            assign src_a_ext  = st_a_ext[k-1];
            assign src_b      = st_b[k-1];
            assign src_acc    = st_acc[k-1];
            assign src_tag    = st_tag[k-1];
        end

        pipe_mul_stage #(
            .WIDTH        (WIDTH),
            .PP_PER_STAGE (PP_PER_STAGE),
            .TAG_W        (TAG_W),
            .STAGE_IDX    (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .load      (st_load[k]),
            .in_valid  (src_valid),
            .in_signed (src_signed),
            .in_a_ext  (src_a_ext),
            .in_b      (src_b),
            .in_acc    (src_acc),
            .in_tag    (src_tag),
            .valid     (st_valid[k]),
            .is_signed (st_signed[k]),
            .a_ext     (st_a_ext[k]),
            .b         (st_b[k]),
            .acc       (st_acc[k]),
            .tag       (st_tag[k])
        );
    end

    always_comb begin
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            cnt = cnt + CNT_W'(st_valid[k]);
        end
        in_flight = cnt;
    end

    assign out_valid = st_valid[NSTAGE-1];
    assign mul_out   = st_acc[NSTAGE-1];
    assign out_tag   = st_tag[NSTAGE-1];

    // Operand copies in the final stage have no consumer.
    assign unused_tail = ^{st_signed[NSTAGE-1], st_a_ext[NSTAGE-1], st_b[NSTAGE-1]};

endmodule
